// File: rtl/hampel_pkg.sv
// Shared types and helpers for the Hampel outlier flagger.
//   FRAC_BITS     : number of fractional bits in the Q8.8 format.
//   q88_t         : 16-bit unsigned Q8.8 value.
//   q88_round_sat : rounds a Q8.8 value to the nearest integer (half rounds
//                   up) and saturates the result to an unsigned width.
package hampel_pkg;

  localparam int FRAC_BITS = 8;

  typedef logic [15:0] q88_t;

  // Adds the half bit to the integer part, then clamps to 2^width-1.
  // The result is returned in 16 bits; callers keep the low width bits.
  function automatic logic [15:0] q88_round_sat(input q88_t v, input int unsigned width);
    int unsigned r;
    int unsigned max_v;
    r     = int'(v >> FRAC_BITS) + int'(v[FRAC_BITS-1]);
    max_v = (32'd1 << width) - 32'd1;
    return 16'((r > max_v) ? max_v : r);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular queue of raw samples waiting for their median/MAD result.
//   clk, rst  : clock, synchronous active-low reset
//   wr_req    : push request (data_rdy), wr_data written at the tail
//   rd_req    : pop request (res_vld), rd_data is the current head
//   rd_ok     : the pop request was honoured this cycle
//   ovf_evt   : push request dropped because the queue was full
//   unf_evt   : pop request arrived with the queue empty
//   pending   : number of stored samples, full / empty flags
// A simultaneous pop frees a slot, so a push into a full queue is accepted
// in the same cycle as a pop.
module sample_fifo
  import hampel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int QDEPTH     = 4,
  localparam int AW        = $clog2(QDEPTH),
  localparam int PW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ok,
  output logic                  ovf_evt,
  output logic                  unf_evt,
  output logic [PW-1:0]         pending,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  wr_ok;

  assign full    = (count == PW'(QDEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_req && !empty;
  assign wr_ok   = wr_req && (!full || rd_ok);
  assign ovf_evt = wr_req && !wr_ok;
  assign unf_evt = rd_req && empty;
  assign rd_data = mem[rd_ptr];
  assign pending = count;

  // Pointers are AW bits wide so they wrap modulo QDEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hampel_flagger.sv
// Hampel outlier flagger: pairs each MADcalc result with the sample it was
// computed for and flags |x - median| > THRESH_K * MAD.
//   clk, rst        : clock, synchronous active-low reset
//   data_in/data_rdy: raw sample stream (strobe, no back-pressure)
//   local_median/MAD/res_vld : result stream from MADcalc (strobe)
//   out_vld/outlier/data_out : result strobe, flag, corrected sample
//   pending         : samples waiting for a result
//   ovf_err/unf_err : sticky drop / orphan-result errors
// Handshake: every *_rdy / *_vld input is a one-cycle strobe with no ready
// back-channel; a transfer happens on each rising edge where it is 1.
// out_vld is likewise a one-cycle strobe, and outlier/data_out hold their
// last values between strobes.
module hampel_flagger
  import hampel_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          QDEPTH     = 4,
  parameter logic [15:0] THRESH_K   = 16'h0300
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_rdy,
  input  logic [15:0]                local_median,
  input  logic [15:0]                MAD,
  input  logic                       res_vld,
  output logic                       out_vld,
  output logic                       outlier,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(QDEPTH):0]    pending,
  output logic                       ovf_err,
  output logic                       unf_err
);

  logic [DATA_WIDTH-1:0] head;
  logic                  pop_ok;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic                  q_full;
  logic                  q_empty;

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .QDEPTH     (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (data_rdy),
    .wr_data (data_in),
    .rd_req  (res_vld),
    .rd_data (head),
    .rd_ok   (pop_ok),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt),
    .pending (pending),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Stage 1 combinational terms, computed from the head sample at pop time.
  q88_t        xq;
  q88_t        diff;
  logic [31:0] prod;
  logic [23:0] thr;

  always_comb begin
    xq   = q88_t'(head) << FRAC_BITS;
    diff = (xq >= local_median) ? (xq - local_median) : (local_median - xq);
    prod = 32'(MAD) * 32'(THRESH_K);
    thr  = 24'(prod >> FRAC_BITS);
  end

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_x;
  q88_t                  s1_diff;
  logic [23:0]           s1_thr;
  q88_t                  s1_med;
  logic                  is_outlier;

  // Strict compare: a deviation exactly equal to the threshold is an inlier.
  assign is_outlier = ({8'd0, s1_diff} > s1_thr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_x     <= '0;
      s1_diff  <= '0;
      s1_thr   <= '0;
      s1_med   <= '0;
      out_vld  <= 1'b0;
      outlier  <= 1'b0;
      data_out <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      s1_vld <= pop_ok;
      if (pop_ok) begin
        s1_x    <= head;
        s1_diff <= diff;
        s1_thr  <= thr;
        s1_med  <= local_median;
      end
      out_vld <= s1_vld;
      if (s1_vld) begin
        outlier  <= is_outlier;
        data_out <= is_outlier ? DATA_WIDTH'(q88_round_sat(s1_med, DATA_WIDTH)) : s1_x;
      end
      if (ovf_evt) ovf_err <= 1'b1;
      if (unf_evt) unf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hampel_flagger.sv
// Directed bench for hampel_flagger with a reference queue model and an
// expected-result scoreboard checked whenever out_vld is seen.
module tb_hampel_flagger;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_rdy;
  logic [15:0] local_median;
  logic [15:0] MAD;
  logic        res_vld;
  logic        out_vld;
  logic        outlier;
  logic [7:0]  data_out;
  logic [2:0]  pending;
  logic        ovf_err;
  logic        unf_err;

  hampel_flagger #(
    .DATA_WIDTH (8),
    .QDEPTH     (4),
    .THRESH_K   (16'h0300)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_rdy     (data_rdy),
    .local_median (local_median),
    .MAD          (MAD),
    .res_vld      (res_vld),
    .out_vld      (out_vld),
    .outlier      (outlier),
    .data_out     (data_out),
    .pending      (pending),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];   // {outlier, data_out}
  logic [7:0] mdl_q[$];   // reference sample queue
  logic       mdl_ovf = 1'b0;
  logic       mdl_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent arithmetic model of the flag/correct rule.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [15:0] med,
                                       input logic [15:0] mad);
    int xq, d, thr, r;
    bit o;
    xq  = int'(x) * 256;
    d   = (xq > int'(med)) ? xq - int'(med) : int'(med) - xq;
    thr = (int'(mad) * 768) / 256;
    o   = (d > thr);
    r   = (int'(med) + 128) / 256;
    if (r > 255) r = 255;
    return o ? {1'b1, 8'(r)} : {1'b0, x};
  endfunction

  // Drives one cycle of inputs (called right after a falling edge), updates
  // the reference model, and returns after the next falling edge.
  task automatic cyc(input logic dr, input logic [7:0] d, input logic rv,
                     input logic [15:0] med, input logic [15:0] mad);
    bit pop_ok, push_ok;
    data_rdy = dr; data_in = d; res_vld = rv; local_median = med; MAD = mad;
    pop_ok  = rv && (mdl_q.size() > 0);
    push_ok = dr && ((mdl_q.size() < 4) || pop_ok);
    if (rv && !pop_ok) mdl_unf = 1'b1;
    if (dr && !push_ok) mdl_ovf = 1'b1;
    if (pop_ok) exp_q.push_back(model(mdl_q.pop_front(), med, mad));
    if (push_ok) mdl_q.push_back(d);
    @(negedge clk);
    data_rdy = 1'b0; res_vld = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 8'd0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_rdy = 1'b0; res_vld = 1'b0;
    exp_q.delete();
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_unf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      idle();
      budget--;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every out_vld must match the oldest expected result.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_vld", 32'd1, 32'd0);
      end else begin
        check("out_result", 32'({outlier, data_out}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; data_in = '0; data_rdy = 1'b0; res_vld = 1'b0;
    local_median = '0; MAD = '0;
    @(negedge clk);
    do_reset();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_outlier", 32'(outlier), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_errs", 32'({ovf_err, unf_err}), 32'd0);

    // Inlier with explicit latency check.
    cyc(1'b1, 8'd100, 1'b0, 16'd0, 16'd0);
    check("inl_pending1", 32'(pending), 32'd1);
    cyc(1'b0, 8'd0, 1'b1, 16'h6400, 16'h0200);
    check("inl_lat_early", 32'(out_vld), 32'd0);
    check("inl_pending0", 32'(pending), 32'd0);
    idle();
    check("inl_lat_vld", 32'(out_vld), 32'd1);
    idle();
    check("inl_vld_pulse", 32'(out_vld), 32'd0);
    check("inl_hold_data", 32'(data_out), 32'd100);

    // Outlier, threshold equality, MAD=0 with rounding, saturation.
    cyc(1'b1, 8'd200, 1'b1, 16'h6400, 16'h0200);
    cyc(1'b0, 8'd0,   1'b1, 16'h6400, 16'h0200);
    cyc(1'b1, 8'd106, 1'b1, 16'h6400, 16'h0200);
    cyc(1'b1, 8'd51,  1'b1, 16'h6400, 16'h0200);
    cyc(1'b1, 8'd50,  1'b1, 16'h3280, 16'h0000);
    cyc(1'b1, 8'd0,   1'b1, 16'h3200, 16'h0000);
    cyc(1'b0, 8'd0,   1'b1, 16'hFF80, 16'h0000);
    drain("drain_thresh");

    // Back-to-back results: three consecutive out_vld cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(7 + i), 1'b0, 16'd0, 16'd0);
    check("b2b_pending", 32'(pending), 32'd3);
    cyc(1'b0, 8'd0, 1'b1, 16'h0700, 16'h0000);
    cyc(1'b0, 8'd0, 1'b1, 16'h0000, 16'h0100);
    check("b2b_vld1", 32'(out_vld), 32'd1);
    cyc(1'b0, 8'd0, 1'b1, 16'h2000, 16'h0000);
    check("b2b_vld2", 32'(out_vld), 32'd1);
    idle();
    check("b2b_vld3", 32'(out_vld), 32'd1);
    idle();
    check("b2b_vld_end", 32'(out_vld), 32'd0);

    // Underflow: result with empty queue produces no output.
    cyc(1'b0, 8'd0, 1'b1, 16'h1000, 16'h0100);
    check("unf_err", 32'(unf_err), 32'(mdl_unf));
    check("unf_ovf_clear", 32'(ovf_err), 32'd0);
    idle();
    idle();
    check("unf_no_vld", 32'(out_vld), 32'd0);

    // Overflow: fifth sample dropped; then push+pop while full.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(10 + i), 1'b0, 16'd0, 16'd0);
    check("ovf_pending", 32'(pending), 32'd4);
    check("ovf_err", 32'(ovf_err), 32'(mdl_ovf));
    cyc(1'b1, 8'd15, 1'b1, 16'h0A00, 16'h0000);
    check("pp_pending", 32'(pending), 32'd4);
    check("pp_pending_model", 32'(pending), 32'(mdl_q.size()));
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 16'h0C00, 16'h0000);
    drain("drain_ovf");
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Reset while a result is in flight.
    cyc(1'b1, 8'd20, 1'b0, 16'd0, 16'd0);
    cyc(1'b1, 8'd21, 1'b0, 16'd0, 16'd0);
    cyc(1'b0, 8'd0, 1'b1, 16'h1400, 16'h0100);
    do_reset();
    check("mrst_no_vld", 32'(out_vld), 32'd0);
    check("mrst_pending", 32'(pending), 32'd0);
    check("mrst_errs", 32'({ovf_err, unf_err}), 32'd0);
    idle();
    check("mrst_no_vld2", 32'(out_vld), 32'd0);
    cyc(1'b1, 8'd30, 1'b0, 16'd0, 16'd0);
    cyc(1'b0, 8'd0, 1'b1, 16'h1E00, 16'h0100);
    drain("drain_post_rst");
    check("post_rst_data", 32'(data_out), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hampel_flagger.md
Name: hampel_flagger

Overview:
- Consumes the MADcalc result stream (local_median, MAD, data_vld) and pairs each result with the sample it was computed for.
- Flags the sample as an outlier when |x - median| > THRESH_K * MAD, and emits the flag plus a corrected sample (median if outlier, else the sample).
- Sits downstream of MADcalc, in parallel with reg_file on the sample input stream; it is the reader of MADcalc's result output.

Parameters:
- DATA_WIDTH, 8, sample width (unsigned integer).
- QDEPTH, 4, depth of the pending-sample queue (power of two, >=2).
- THRESH_K, 'h0300, outlier multiplier, unsigned Q8.8 (3.0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- data_in  in  DATA_WIDTH  raw sample, same stream fed to reg_file.
- data_rdy  in  1  one-cycle strobe: data_in valid.
- local_median  in  16  window median, unsigned Q8.8.
- MAD  in  16  scaled MAD, unsigned Q8.8.
- res_vld  in  1  one-cycle strobe from MADcalc data_vld: median/MAD valid.
- out_vld  out  1  one-cycle strobe: outputs below valid.
- outlier  out  1  1 = sample rejected.
- data_out  out  DATA_WIDTH  corrected sample.
- pending  out  $clog2(QDEPTH)+1  samples awaiting a result.
- ovf_err  out  1  sticky: sample dropped, queue full.
- unf_err  out  1  sticky: result arrived with empty queue.

Behaviour:
- Reset (rst==0 at posedge): queue emptied (pointers 0, pending 0); out_vld, outlier, data_out, ovf_err, unf_err all 0; pipeline valids cleared. In-flight results are discarded. Reset has priority over all other inputs.
- Queue is a circular FIFO of QDEPTH samples. Pointers wrap modulo QDEPTH. Full is pending==QDEPTH.
- Push: data_rdy=1 and not full writes data_in at the tail.
- Push when full: the sample is dropped, ovf_err is set, and the queue is unchanged.
- Pop: res_vld=1 and not empty reads the head sample x and launches stage 1.
- Pop when empty: unf_err is set, nothing is launched, and no out_vld follows.
- Simultaneous push+pop: both happen in the same cycle; pending is unchanged. Push while full and pop in the same cycle is NOT an overflow, because the pop frees the slot first.
- Stage 1 (registered at the pop edge):
  - xq = {x, 8'h00} (Q8.8, 16 bits).
  - diff = |xq - local_median|, 16-bit unsigned.
  - prod = MAD * THRESH_K, 32 bits; thr = prod[31:8].
  - The median is held for stage 2.
- Stage 2 (registered):
  - outlier = (diff > thr), strict; equality is an inlier.
  - data_out = x if inlier.
  - If outlier, data_out = round(median) = median[15:8] + median[7], saturated to 2^DATA_WIDTH-1.
  - out_vld = 1 for exactly one cycle.
- Latency: out_vld rises 2 cycles after the res_vld edge that popped the sample.
- Throughput: one result per cycle; back-to-back res_vld is supported.
- outlier and data_out hold their last values while out_vld=0.
- MAD == 0: thr = 0, so any diff > 0 is an outlier and diff == 0 is an inlier.
- ovf_err and unf_err clear only on reset.

Decomposition:
- Package hampel_pkg:
  - Q8.8 fraction-bits constant (8).
  - typedef q88_t (logic [15:0]).
  - function q88_round_sat(q88_t, width).
- One sub-module: sample_fifo (circular queue with pending count and full/empty), parameterised by DATA_WIDTH and QDEPTH.
- Compare/correct pipeline stays in hampel_flagger.

Test Plan:
- Inlier: push x=100; res_vld with median='h6400, MAD='h0200 -> 2 cycles later out_vld=1, outlier=0, data_out=100, pending=0.
- Outlier and threshold equality:
  - push 200, res_vld with median='h6400, MAD='h0200 -> outlier=1, data_out=100.
  - push 106, same result values -> diff=thr='h0600 -> outlier=0, data_out=106.
- MAD=0 and rounding: push 51, res_vld median='h3280, MAD=0 -> outlier=1, data_out=51 (50.5 rounds up); push 50, median='h3200 -> outlier=0.
- Overflow and simultaneous push/pop:
  - push 5 samples (10..14) with no results -> ovf_err=1, pending=4, sample 14 dropped.
  - next, data_rdy and res_vld in the same cycle -> pending stays 4, no new error, popped sample is 10.
- Underflow and back-to-back results:
  - res_vld on empty -> unf_err=1, no out_vld.
  - push 3 samples then 3 consecutive res_vld -> 3 consecutive out_vld cycles, in FIFO order.
- Reset mid-operation: push 2 samples, res_vld, drive rst=0 the next cycle -> no out_vld, pending=0, errors cleared; after rst=1 the queue operates normally.
